// File: rtl/data_mem_responder.sv
// Memory-stage data-memory responder: word RAM with byte-lane writes plus an
// MMIO window bridging to the UART (TX FIFO, RX holding register, status).
module data_mem_responder #(
   parameter int          DEPTH     = 1024,
   parameter logic [31:0] MMIO_BASE = 32'hAAAAA000,
   parameter int          TX_DEPTH  = 4
) (
   input  logic        clk,
   input  logic        Rst,
   input  logic        mem_wea,
   input  logic        mem_rd,
   input  logic [3:0]  mem_en,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_din,
   output logic [31:0] mem_dout,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready
);
   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(TX_DEPTH);
   localparam int PW = TW + 1;

   logic [31:0] ram [DEPTH];
   logic [7:0]  tx_mem [TX_DEPTH];

   logic          ram_hit, mmio_hit, sel_status, sel_txdata, sel_rxdata, full_word;
   logic [AW-1:0] word_idx;
   logic [31:0]   din_rot, rd_word;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic          tx_empty, tx_full, tx_ovf, tx_pop, push_req, tx_push, ovf_set, ovf_clr;
   logic [7:0]    rx_hold;
   logic          rx_full, rx_pop, rx_load;

   assign ram_hit    = (mem_addr[31:AW+2] == '0);
   assign word_idx   = mem_addr[AW+1:2];
   assign mmio_hit   = (mem_addr[31:12] == MMIO_BASE[31:12]);
   assign sel_status = mmio_hit && (mem_addr[11:0] == 12'h000);
   assign sel_txdata = mmio_hit && (mem_addr[11:0] == 12'h004);
   assign sel_rxdata = mmio_hit && (mem_addr[11:0] == 12'h008);
   assign full_word  = (mem_en == 4'b1111);

   // Store data is LSB-justified; rotate it onto the addressed lanes so a
   // half at offset 3 wraps into lane 0 of the same word.
   always_comb begin
      din_rot = mem_din;
      case (mem_addr[1:0])
         2'd1: din_rot = {mem_din[23:0], mem_din[31:24]};
         2'd2: din_rot = {mem_din[15:0], mem_din[31:16]};
         2'd3: din_rot = {mem_din[7:0],  mem_din[31:8]};
         default: din_rot = mem_din;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!Rst && mem_wea && ram_hit) begin
         for (int i = 0; i < 4; i++)
            if (mem_en[i]) ram[word_idx][8*i +: 8] <= din_rot[8*i +: 8];
      end
   end

   // Read is sampled from pre-edge contents, giving read-before-write.
   always_comb begin
      rd_word = '0;
      if (ram_hit)
         rd_word = ram[word_idx];
      else if (sel_status)
         rd_word = {27'b0, tx_ovf, rx_full, tx_empty, tx_full};
      else if (sel_rxdata && rx_full)
         rd_word = {24'b0, rx_hold};
   end

   always_ff @(posedge clk) begin
      if (Rst) mem_dout <= '0;
      else     mem_dout <= rd_word;
   end

   assign tx_empty = (wr_ptr == rd_ptr);
   assign tx_full  = (wr_ptr[TW-1:0] == rd_ptr[TW-1:0]) && (wr_ptr[TW] != rd_ptr[TW]);
   assign tx_valid = !tx_empty;
   assign tx_data  = tx_mem[rd_ptr[TW-1:0]];
   assign tx_pop   = tx_valid && tx_ready;
   assign push_req = mem_wea && full_word && sel_txdata;
   assign tx_push  = push_req && (!tx_full || tx_pop);
   assign ovf_set  = push_req && tx_full && !tx_pop;
   assign ovf_clr  = mem_wea && full_word && sel_status && mem_din[3];

   always_ff @(posedge clk) begin
      if (Rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         tx_ovf <= 1'b0;
      end else begin
         if (tx_push) wr_ptr <= wr_ptr + PW'(1);
         if (tx_pop)  rd_ptr <= rd_ptr + PW'(1);
         if (ovf_set)      tx_ovf <= 1'b1;
         else if (ovf_clr) tx_ovf <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!Rst && tx_push) tx_mem[wr_ptr[TW-1:0]] <= mem_din[7:0];
   end

   assign rx_ready = !rx_full;
   assign rx_pop   = mem_rd && !mem_wea && sel_rxdata && rx_full;
   assign rx_load  = rx_valid && !rx_full;

   always_ff @(posedge clk) begin
      if (Rst)          rx_full <= 1'b0;
      else if (rx_pop)  rx_full <= 1'b0;
      else if (rx_load) rx_full <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!Rst && rx_load) rx_hold <= rx_data;
   end
endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder against a queue/array reference
// model, plus directed scenarios with literal expectations.
module tb_data_mem_responder;
   localparam int          DEPTH = 1024;
   localparam logic [31:0] BASE  = 32'hAAAAA000;
   localparam int          TXD   = 4;

   logic        clk = 0, Rst = 0;
   logic        mem_wea = 0, mem_rd = 0;
   logic [3:0]  mem_en = 4'hF;
   logic [31:0] mem_addr = BASE, mem_din = 0;
   logic [31:0] mem_dout;
   logic [7:0]  tx_data, rx_data = 0;
   logic        tx_valid, tx_ready = 0, rx_valid = 0, rx_ready;

   data_mem_responder #(.DEPTH(DEPTH), .MMIO_BASE(BASE), .TX_DEPTH(TXD)) dut (
      .clk(clk), .Rst(Rst), .mem_wea(mem_wea), .mem_rd(mem_rd), .mem_en(mem_en),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready));

   always #5 clk = ~clk;

   int tests = 0, fails = 0;

   // reference state
   logic [7:0]  mram [DEPTH][4];
   bit   [3:0]  kb [DEPTH];
   logic [7:0]  q [$];
   bit          m_ovf = 0, m_rxf = 0;
   logic [7:0]  m_hold = 0;
   logic [31:0] exp_dout = 0, exp_mask = '1;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_edge();
      logic [31:0] a;
      int unsigned wi;
      bit ram_h, mmio_h, pop, fw, push_req, ovf_now;
      a = mem_addr;
      ram_h  = (a < DEPTH * 4);
      mmio_h = (a[31:12] == BASE[31:12]);
      wi     = (a / 4) % DEPTH;
      if (Rst) begin
         q.delete(); m_ovf = 0; m_rxf = 0; exp_dout = 0; exp_mask = '1;
         return;
      end
      exp_dout = 0; exp_mask = '1;
      if (ram_h) begin
         for (int b = 0; b < 4; b++) begin
            exp_dout[8*b +: 8] = mram[wi][b];
            if (!kb[wi][b]) exp_mask[8*b +: 8] = 8'h00;
         end
      end else if (mmio_h && a[11:0] == 12'h000)
         exp_dout = {27'b0, m_ovf, m_rxf, q.size() == 0, q.size() == TXD};
      else if (mmio_h && a[11:0] == 12'h008 && m_rxf)
         exp_dout = {24'b0, m_hold};

      pop      = (q.size() > 0) && tx_ready;
      fw       = mem_wea && mem_en == 4'hF;
      push_req = fw && mmio_h && a[11:0] == 12'h004;
      ovf_now  = push_req && q.size() == TXD && !pop;
      if (pop) void'(q.pop_front());
      if (push_req && !ovf_now) q.push_back(mem_din[7:0]);
      if (ovf_now) m_ovf = 1;
      else if (fw && mmio_h && a[11:0] == 12'h000 && mem_din[3]) m_ovf = 0;

      if (mem_rd && !mem_wea && mmio_h && a[11:0] == 12'h008 && m_rxf) m_rxf = 0;
      else if (rx_valid && !m_rxf) begin m_rxf = 1; m_hold = rx_data; end

      if (mem_wea && ram_h)
         for (int l = 0; l < 4; l++)
            if (mem_en[l]) begin
               mram[wi][l] = mem_din[8*((l - a[1:0]) & 3) +: 8];
               kb[wi][l] = 1;
            end
   endtask

   task automatic step();
      model_edge();
      @(posedge clk); #1;
      chk("dout", mem_dout & exp_mask, exp_dout & exp_mask);
      chk("tx_valid", 32'(tx_valid), 32'(q.size() > 0));
      if (q.size() > 0) chk("tx_data", 32'(tx_data), 32'(q[0]));
      chk("rx_ready", 32'(rx_ready), 32'(!m_rxf));
   endtask

   task automatic req(bit w, bit r, logic [3:0] e, logic [31:0] a, logic [31:0] d);
      mem_wea = w; mem_rd = r; mem_en = e; mem_addr = a; mem_din = d;
      step();
      mem_wea = 0; mem_rd = 0; mem_en = 4'hF; mem_addr = BASE;
   endtask

   initial begin
      int r, off, wsel;
      logic [31:0] a;
      logic [3:0]  e;
      for (int i = 0; i < DEPTH; i++) kb[i] = 0;

      Rst = 1; step(); Rst = 0;
      chk("rst_dout", mem_dout, 32'h0);
      chk("rst_txv", 32'(tx_valid), 32'h0);
      chk("rst_rxr", 32'(rx_ready), 32'h1);
      req(0, 0, 4'hF, BASE, 0);
      chk("rst_status", mem_dout, 32'h2);

      req(1, 0, 4'hF, 32'h10, 32'hDEADBEEF);
      req(0, 1, 4'hF, 32'h10, 0);
      chk("sw_lw", mem_dout, 32'hDEADBEEF);
      req(1, 0, 4'b0010, 32'h11, 32'h000000A5);
      req(1, 0, 4'b1001, 32'h13, 32'h00001234);
      req(0, 1, 4'hF, 32'h10, 0);
      chk("sb_sh_wrap", mem_dout, 32'h34ADA512);

      tx_ready = 0;
      for (int k = 1; k <= 5; k++) req(1, 0, 4'hF, BASE + 4, k);
      req(0, 0, 4'hF, BASE, 0);
      chk("status_full_ovf", mem_dout, 32'h9);
      req(1, 0, 4'hF, BASE, 32'h8);
      req(0, 0, 4'hF, BASE, 0);
      chk("status_ovf_clr", mem_dout, 32'h1);
      tx_ready = 1;
      for (int k = 1; k <= 4; k++) begin
         chk("tx_seq", 32'(tx_data), k);
         step();
      end
      chk("tx_drained", 32'(tx_valid), 32'h0);
      tx_ready = 0;

      rx_valid = 1; rx_data = 8'h5A; step(); rx_valid = 0;
      chk("rx_full", 32'(rx_ready), 32'h0);
      req(0, 0, 4'hF, BASE, 0);
      chk("status_rx", mem_dout, 32'h6);
      req(0, 1, 4'hF, BASE + 8, 0);
      chk("rx_pop_data", mem_dout, 32'h5A);
      chk("rx_pop_ready", 32'(rx_ready), 32'h1);
      req(0, 1, 4'hF, BASE + 8, 0);
      chk("rx_empty_read", mem_dout, 32'h0);

      req(1, 0, 4'b0011, BASE + 4, 32'h77);
      chk("tx_partial_nopush", 32'(tx_valid), 32'h0);
      req(1, 0, 4'hF, 32'h00400000, 32'hCAFEF00D);
      req(0, 1, 4'hF, 32'h00400000, 0);
      chk("unmapped_read", mem_dout, 32'h0);
      req(0, 1, 4'hF, 32'h10, 0);
      chk("ram_untouched", mem_dout, 32'h34ADA512);

      req(1, 0, 4'hF, BASE + 4, 32'h11);
      req(1, 0, 4'hF, BASE + 4, 32'h22);
      rx_valid = 1; rx_data = 8'h33; step(); rx_valid = 0;
      Rst = 1; req(1, 0, 4'hF, BASE + 4, 32'h44); Rst = 0;
      chk("rst_mid_txv", 32'(tx_valid), 32'h0);
      chk("rst_mid_rxr", 32'(rx_ready), 32'h1);
      chk("rst_mid_dout", mem_dout, 32'h0);
      req(0, 0, 4'hF, BASE, 0);
      chk("rst_mid_status", mem_dout, 32'h2);

      for (int i = 0; i < 16; i++) req(1, 0, 4'hF, i * 4, $urandom);

      for (int n = 0; n < 3000; n++) begin
         r = $urandom_range(0, 9);
         e = 4'hF;
         if (r <= 5) begin
            off = $urandom_range(0, 3);
            wsel = $urandom_range(0, 2);
            a = $urandom_range(0, 15) * 4 + off;
            if (wsel == 0) begin e = 4'hF; a[1:0] = 0; end
            else if (wsel == 1) e = 4'(1 << off);
            else e = (off == 3) ? 4'b1001 : 4'(3 << off);
         end else if (r == 6) a = BASE;
         else if (r == 7) a = BASE + 4;
         else if (r == 8) a = BASE + 8;
         else begin
            case ($urandom_range(0, 2))
               0: a = BASE + 32'hC;
               1: a = 32'h00400000 + $urandom_range(0, 15) * 4;
               default: a = {20'hFFFFF, 12'h000};
            endcase
         end
         if (r >= 6 && $urandom_range(0, 7) == 0) e = 4'b0011;
         mem_wea  = ($urandom_range(0, 9) < 4);
         mem_rd   = $urandom_range(0, 1);
         mem_en   = e;
         mem_addr = a;
         mem_din  = $urandom;
         tx_ready = ($urandom_range(0, 2) == 0);
         rx_valid = ($urandom_range(0, 9) < 3);
         rx_data  = 8'($urandom);
         Rst      = ($urandom_range(0, 99) == 0);
         step();
      end
      Rst = 0; mem_wea = 0; mem_rd = 0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
